vend_ctrl_param: RTL and testbench

Parametrised vending-machine controller, the next generation of the fixed 3-item, 50-credit vending FSM in the lab series. It accepts 5/10/50 coins, validates product selections against per-item price and stock, issues a one-cycle drop pulse, and refunds the remaining credit as paced single-unit change pulses. It sits between debounced and synchronised front-panel buttons / coin acceptor and the product/change actuators. The display driver reads `credit` directly.

---
 rtl/vend_ctrl_param.sv | 131 +++++++++++++
 tb/tb_vend_ctrl_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller with coin accept, priced/stocked
// selection, one-cycle drop pulses and paced 5-unit change refund.
module vend_ctrl_param #(
    parameter int N_ITEMS = 3,
    parameter int CREDIT_W = 8,
    parameter int MAX_CREDIT = 50,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15},
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 4,
    parameter int CHG_GAP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_50,
    input  logic [N_ITEMS-1:0]  sel,
    input  logic                cancel,
    input  logic                restock,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  avail,
    output logic [N_ITEMS-1:0]  sold_out,
    output logic [N_ITEMS-1:0]  drop,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [1:0]          state
);
    localparam int IDX_W = N_ITEMS > 1 ? $clog2(N_ITEMS) : 1;
    localparam int GAP_W = $clog2(CHG_GAP + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CHANGE = 2'd1} state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [STOCK_W-1:0]  stock_q [N_ITEMS];
    logic [2:0]          coin_hist_q;
    logic [GAP_W-1:0]    gap_q;
    logic [N_ITEMS-1:0]  drop_q;
    logic                change_pulse_q;
    logic                coin_reject_q;

    logic [2:0]          coin_edge;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum_d;
    logic                many_coins;
    logic                coin_fits;
    logic                sel_hit;
    logic [IDX_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] price;

    always_comb begin
        coin_edge  = {coin_50, coin_10, coin_5} & ~coin_hist_q;
        coin_val   = coin_edge[2] ? CREDIT_W'(50) : coin_edge[1] ? CREDIT_W'(10) :
                     coin_edge[0] ? CREDIT_W'(5) : '0;
        many_coins = (coin_edge & (coin_edge - 3'd1)) != 3'd0;
        coin_sum_d = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits  = coin_sum_d <= (CREDIT_W+1)'(MAX_CREDIT);
        sel_hit    = 1'b0;
        sel_idx    = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        price = PRICE_LIST[sel_idx*CREDIT_W +: CREDIT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            coin_hist_q    <= '0;
            gap_q          <= '0;
            drop_q         <= '0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            coin_hist_q    <= {coin_50, coin_10, coin_5};
            drop_q         <= '0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            if (state_q == IDLE) begin
                // a cancel consumes the cycle, so any coin edge alongside it is refused
                if (cancel && credit_q != '0) begin
                    state_q       <= CHANGE;
                    gap_q         <= '0;
                    coin_reject_q <= |coin_edge;
                end else if (|coin_edge) begin
                    coin_reject_q <= many_coins || !coin_fits;
                    if (coin_fits) credit_q <= coin_sum_d[CREDIT_W-1:0];
                end else if (sel_hit && credit_q >= price && stock_q[sel_idx] != '0) begin
                    credit_q          <= credit_q - price;
                    stock_q[sel_idx]  <= stock_q[sel_idx] - 1'b1;
                    drop_q[sel_idx]   <= 1'b1;
                    if (credit_q != price) begin
                        state_q <= CHANGE;
                        gap_q   <= '0;
                    end
                end
            end else begin
                coin_reject_q <= |coin_edge;
                if (credit_q == '0) begin
                    state_q <= IDLE;
                end else if (gap_q == '0) begin
                    change_pulse_q <= 1'b1;
                    credit_q       <= credit_q - CREDIT_W'(5);
                    gap_q          <= GAP_W'(CHG_GAP - 1);
                end else begin
                    gap_q <= gap_q - 1'b1;
                end
            end
            if (restock) begin
                for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end
    end

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
        assign sold_out[g] = stock_q[g] == '0;
        assign avail[g]    = state_q == IDLE && stock_q[g] != '0 &&
                             credit_q >= PRICE_LIST[g*CREDIT_W +: CREDIT_W];
    end

    assign credit       = credit_q;
    assign drop         = drop_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign state        = state_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: directed test-plan scenarios plus random stimulus checked
// against a schedule-based reference model of the vending controller.
module tb_vend_ctrl_param;
    localparam int N = 3;
    localparam int CW = 8;
    localparam int MAXC = 50;
    localparam int INIT = 4;
    localparam int GAP = 2;
    localparam int PRICE [N] = '{15, 20, 25};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          coin_5 = 1'b0, coin_10 = 1'b0, coin_50 = 1'b0;
    logic [N-1:0]  sel = '0;
    logic          cancel = 1'b0, restock = 1'b0;
    logic [CW-1:0] credit;
    logic [N-1:0]  avail, sold_out, drop;
    logic          change_pulse, coin_reject;
    logic [1:0]    state;

    vend_ctrl_param #(
        .N_ITEMS(N), .CREDIT_W(CW), .MAX_CREDIT(MAXC),
        .PRICE_LIST({8'd25, 8'd20, 8'd15}),
        .STOCK_W(4), .INIT_STOCK(INIT), .CHG_GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .sel(sel), .cancel(cancel), .restock(restock), .credit(credit), .avail(avail),
        .sold_out(sold_out), .drop(drop), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .state(state)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: refund is a precomputed pulse schedule from the entry edge
    int       m_credit;
    int       m_stock [N];
    bit       m_chg;
    int       m_enter, m_units, n_edge;
    logic [2:0]   m_hist;
    logic [N-1:0] m_drop;
    bit       m_pulse, m_rej;

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < N; i++) m_stock[i] = INIT;
        m_chg = 0;
        m_hist = '0;
        m_drop = '0;
        m_pulse = 0;
        m_rej = 0;
    endtask

    task automatic model_enter();
        m_chg = 1;
        m_enter = n_edge;
        m_units = m_credit / 5;
    endtask

    task automatic model_step(input logic [2:0] c, input logic [N-1:0] s, input logic cn, input logic rs);
        logic [2:0] e;
        int v, k, pick;
        n_edge++;
        e = c & ~m_hist;
        m_hist = c;
        m_drop = '0;
        m_pulse = 0;
        m_rej = 0;
        if (!m_chg) begin
            if (cn && m_credit > 0) begin
                model_enter();
                m_rej = e != 0;
            end else if (e != 0) begin
                v = e[2] ? 50 : (e[1] ? 10 : 5);
                m_rej = ($countones(e) > 1) || (m_credit + v > MAXC);
                if (m_credit + v <= MAXC) m_credit += v;
            end else begin
                pick = -1;
                for (int i = N - 1; i >= 0; i--) if (s[i]) pick = i;
                if (pick >= 0 && m_credit >= PRICE[pick] && m_stock[pick] > 0) begin
                    m_credit -= PRICE[pick];
                    m_stock[pick]--;
                    m_drop[pick] = 1'b1;
                    if (m_credit > 0) model_enter();
                end
            end
        end else begin
            m_rej = e != 0;
            k = n_edge - m_enter - 1;
            if (k >= 0 && k % GAP == 0 && k / GAP < m_units) begin
                m_pulse = 1;
                m_credit -= 5;
            end else if (k == (m_units - 1) * GAP + 1) begin
                m_chg = 0;
            end
        end
        if (rs) for (int i = 0; i < N; i++) m_stock[i] = INIT;
    endtask

    task automatic check_outputs();
        logic [N-1:0] ea, es;
        for (int i = 0; i < N; i++) begin
            es[i] = m_stock[i] == 0;
            ea[i] = !m_chg && m_credit >= PRICE[i] && m_stock[i] != 0;
        end
        check("credit", credit, m_credit);
        check("state", state, m_chg);
        check("drop", drop, m_drop);
        check("change_pulse", change_pulse, m_pulse);
        check("coin_reject", coin_reject, m_rej);
        check("avail", avail, ea);
        check("sold_out", sold_out, es);
    endtask

    task automatic cyc(input logic [2:0] c, input logic [N-1:0] s, input logic cn, input logic rs);
        {coin_50, coin_10, coin_5} = c;
        sel = s;
        cancel = cn;
        restock = rs;
        @(posedge clk);
        model_step(c, s, cn, rs);
        #1;
        check_outputs();
    endtask

    task automatic coin(input logic [2:0] c);
        cyc(c, '0, 0, 0);
        cyc(3'b000, '0, 0, 0);
    endtask

    task automatic do_reset();
        {coin_50, coin_10, coin_5} = 3'b000;
        sel = '0;
        cancel = 0;
        restock = 0;
        rst_n = 0;
        #2;
        model_reset();
        check("rst_credit", credit, 0);
        check("rst_state", state, 0);
        check("rst_pulse", change_pulse, 0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    int dut_pulses, model_pulses;

    initial begin
        n_edge = 0;
        do_reset();

        repeat (5) cyc(3'b010, '0, 0, 0);
        check("s1_credit", credit, 10);
        cyc(3'b000, '0, 0, 0);

        do_reset();
        coin(3'b100);
        cyc(3'b001, '0, 0, 0);
        check("s2_reject", coin_reject, 1);
        check("s2_credit", credit, 50);
        check("s2_avail", avail, 3'b111);
        cyc(3'b000, '0, 0, 0);

        do_reset();
        repeat (3) coin(3'b010);
        cyc(3'b000, 3'b010, 0, 0);
        check("s3_drop", drop, 3'b010);
        check("s3_credit", credit, 10);
        dut_pulses = 0;
        repeat (10) begin
            cyc(3'b000, '0, 0, 0);
            dut_pulses += int'(change_pulse);
        end
        check("s3_pulses", dut_pulses, 2);
        check("s3_idle", state, 0);

        do_reset();
        coin(3'b010);
        coin(3'b001);
        cyc(3'b000, 3'b110, 0, 0);
        check("s4_no_drop", drop, 0);
        cyc(3'b000, 3'b001, 0, 0);
        check("s4_drop", drop, 3'b001);
        cyc(3'b000, '0, 0, 0);
        check("s4_state", state, 0);

        do_reset();
        repeat (INIT) begin
            coin(3'b010);
            coin(3'b001);
            cyc(3'b000, 3'b001, 0, 0);
        end
        check("s5_sold_out", sold_out[0], 1);
        coin(3'b010);
        coin(3'b001);
        cyc(3'b000, 3'b001, 0, 0);
        check("s5_ignored", credit, 15);
        cyc(3'b000, '0, 0, 1);
        check("s5_restock", sold_out[0], 0);

        do_reset();
        coin(3'b010);
        coin(3'b010);
        coin(3'b001);
        cyc(3'b000, '0, 1, 0);
        dut_pulses = 0;
        model_pulses = 0;
        for (int i = 0; i < 40 && model_pulses < 2; i++) begin
            cyc(i == 1 ? 3'b001 : 3'b000, '0, 0, 0);
            model_pulses += int'(m_pulse);
            dut_pulses += int'(change_pulse);
        end
        check("s6_pulses_before_reset", dut_pulses, 2);
        do_reset();
        dut_pulses = 0;
        repeat (15) begin
            cyc(3'b000, '0, 0, 0);
            dut_pulses += int'(change_pulse);
        end
        check("s6_no_pulses_after_reset", dut_pulses, 0);

        do_reset();
        for (int t = 0; t < 1500; t++) begin
            logic [2:0] c;
            logic [N-1:0] s;
            c = {$urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc(c, s, $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
